// File: rtl/udc_pkg.sv
// ---------------------------------------------------------------------------
// udc_pkg
// Shared definitions for the up/down count sequencer:
//   - udc_state_e : run-control states (IDLE, RUN_UP, RUN_DOWN, PAUSED)
//   - udc_cmd_e   : command codes carried on the cmd port
//   - DS_*        : direction/state segment patterns
//   - ds_pattern(): maps a state to its segment pattern
// Optional feature macro used by the top: UDC_PINGPONG_EN.
// ---------------------------------------------------------------------------
package udc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN_UP   = 2'd1,
        ST_RUN_DOWN = 2'd2,
        ST_PAUSED   = 2'd3
    } udc_state_e;

    typedef enum logic [1:0] {
        CMD_UP    = 2'b00,
        CMD_DOWN  = 2'b01,
        CMD_PAUSE = 2'b10,
        CMD_CLEAR = 2'b11
    } udc_cmd_e;

    localparam logic [7:0] DS_IDLE     = 8'b0000_0000;
    localparam logic [7:0] DS_RUN_UP   = 8'b0011_1110;
    localparam logic [7:0] DS_RUN_DOWN = 8'b0011_1101;
    localparam logic [7:0] DS_PAUSED   = 8'b0100_0000;

    function automatic logic [7:0] ds_pattern(input udc_state_e s);
        logic [7:0] p;
        case (s)
            ST_RUN_UP:   p = DS_RUN_UP;
            ST_RUN_DOWN: p = DS_RUN_DOWN;
            ST_PAUSED:   p = DS_PAUSED;
            default:     p = DS_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/udc_prescaler.sv
// ---------------------------------------------------------------------------
// udc_prescaler
// Divides clk into count ticks. The counter runs 0..DIV-1 while enabled and
// is held at 0 while disabled or cleared.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous reset, active low
//   i_clr   in  restart the count from 0 on the next edge
//   i_en    in  count enable (asserted in the run states)
//   o_tick  out 1 on the last cycle of each DIV-cycle period while enabled
// ---------------------------------------------------------------------------
module udc_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_last & i_en;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/up_down_count_sequencer.sv
// ---------------------------------------------------------------------------
// up_down_count_sequencer
// Run-control sequencer for the up/down display counter. Accepts UP, DOWN,
// PAUSE and CLEAR commands, steps the count once per prescaler tick and
// drives the count, a direction segment pattern, a wrap pulse and busy.
//
// Handshake: a command transfers on a posedge where cmd_valid & cmd_ready.
// cmd_ready drops only on tick cycles, so a command that coincides with a
// step waits one cycle and sees the already-stepped count.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active low
//   cmd_valid  in   command present
//   cmd        in   00 UP, 01 DOWN, 10 PAUSE, 11 CLEAR
//   cmd_ready  out  command may be accepted this cycle
//   out        out  current count (registered)
//   DS         out  direction/state segment pattern (registered)
//   sett       out  digit enable, constant 1
//   tc         out  1-cycle pulse after a terminal-count step (registered)
//   busy       out  1 in RUN_UP / RUN_DOWN (combinational from state)
//
// Build option: define UDC_PINGPONG_EN to reverse direction at the terminal
// count instead of wrapping modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module up_down_count_sequencer
    import udc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       DS,
    output logic             sett,
    output logic             tc,
    output logic             busy
);

    udc_state_e       r_state;
    udc_state_e       w_state_next;
    logic             r_dir_down;
    logic             w_dir_next;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_next;
    logic             r_tc;
    logic [7:0]       r_ds;
    logic [7:0]       w_ds_next;
    logic             w_busy;
    logic             w_run;
    logic             w_tick;
    logic             w_accept;
    logic             w_wrap;
    udc_cmd_e         w_cmd;

    assign w_cmd    = udc_cmd_e'(cmd);
    assign w_run    = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);
    assign w_accept = cmd_valid & ~w_tick;

    // Any accepted command restarts the prescaler, so UP in RUN_UP (or DOWN
    // in RUN_DOWN) lands its next step a full period after acceptance.
    udc_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_en   (w_run),
        .o_tick (w_tick)
    );

    // Terminal step: all-ones going up, zero going down.
    assign w_wrap = w_tick & (r_dir_down ? (r_out == '0) : (r_out == '1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_dir_down <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_dir_down <= w_dir_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir_down;
        if (w_tick) begin
`ifdef UDC_PINGPONG_EN
            if (w_wrap) begin
                w_state_next = r_dir_down ? ST_RUN_UP : ST_RUN_DOWN;
                w_dir_next   = ~r_dir_down;
            end
`endif
        end else if (w_accept) begin
            case (w_cmd)
                CMD_UP: begin
                    w_state_next = ST_RUN_UP;
                    w_dir_next   = 1'b0;
                end
                CMD_DOWN: begin
                    w_state_next = ST_RUN_DOWN;
                    w_dir_next   = 1'b1;
                end
                CMD_PAUSE: begin
                    if (w_run) begin
                        w_state_next = ST_PAUSED;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_dir_next   = 1'b0;
                end
            endcase
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_busy    = (r_state == ST_RUN_UP) || (r_state == ST_RUN_DOWN);
        w_ds_next = ds_pattern(w_state_next);
    end

    // Count datapath: only a tick or CLEAR changes the value.
    always_comb begin
        w_out_next = r_out;
        if (w_tick) begin
`ifdef UDC_PINGPONG_EN
            if (w_wrap) begin
                w_out_next = r_dir_down ? WIDTH'(1) : ('1 - WIDTH'(1));
            end else begin
                w_out_next = r_dir_down ? (r_out - WIDTH'(1)) : (r_out + WIDTH'(1));
            end
`else
            w_out_next = r_dir_down ? (r_out - WIDTH'(1)) : (r_out + WIDTH'(1));
`endif
        end else if (w_accept && (w_cmd == CMD_CLEAR)) begin
            w_out_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out <= '0;
            r_tc  <= 1'b0;
            r_ds  <= DS_IDLE;
        end else begin
            r_out <= w_out_next;
            r_tc  <= w_wrap;
            r_ds  <= w_ds_next;
        end
    end

    assign cmd_ready = ~w_tick;
    assign out       = r_out;
    assign DS        = r_ds;
    assign sett      = 1'b1;
    assign tc        = r_tc;
    assign busy      = w_busy;

endmodule

// File: tb/tb_up_down_count_sequencer.sv
// ---------------------------------------------------------------------------
// tb_up_down_count_sequencer
// Self-checking bench for up_down_count_sequencer (WIDTH=4, DIV=4). The
// reference model tracks the mode, the count and the absolute edge number of
// the next scheduled step; every cycle it predicts cmd_ready and, after the
// edge, out / DS / tc / busy / sett.
// ---------------------------------------------------------------------------
module tb_up_down_count_sequencer;

  localparam int WIDTH = 4;
  localparam int DIV   = 4;

  localparam int M_IDLE   = 0;
  localparam int M_UP     = 1;
  localparam int M_DOWN   = 2;
  localparam int M_PAUSED = 3;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic [WIDTH-1:0] out;
  logic [7:0]       DS;
  logic             sett;
  logic             tc;
  logic             busy;

  int n_checks;
  int n_fail;

  // reference model state
  int m_mode;
  int m_cnt;
  int m_tc;
  int m_edge;
  int m_next_step;

  up_down_count_sequencer #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .out       (out),
    .DS        (DS),
    .sett      (sett),
    .tc        (tc),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_edge);
    end
  endtask

  function automatic int exp_ready();
    return ((m_mode == M_UP || m_mode == M_DOWN) && (m_edge + 1 == m_next_step)) ? 0 : 1;
  endfunction

  function automatic logic [7:0] exp_ds();
    case (m_mode)
      M_UP:     return 8'b0011_1110;
      M_DOWN:   return 8'b0011_1101;
      M_PAUSED: return 8'b0100_0000;
      default:  return 8'b0000_0000;
    endcase
  endfunction

  // Advance the model across one posedge with the inputs applied there.
  task automatic model_edge(input logic v, input logic [1:0] c, input logic rn);
    bit step;
    m_edge++;
    step = (m_mode == M_UP || m_mode == M_DOWN) && (m_edge == m_next_step);
    m_tc = 0;
    if (!rn) begin
      m_mode = M_IDLE;
      m_cnt  = 0;
    end else if (step) begin
      m_next_step = m_edge + DIV;
      if (m_mode == M_UP) begin
        if (m_cnt == 15) begin
          m_tc = 1;
`ifdef UDC_PINGPONG_EN
          m_mode = M_DOWN;
          m_cnt  = 14;
`else
          m_cnt  = 0;
`endif
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else begin
        if (m_cnt == 0) begin
          m_tc = 1;
`ifdef UDC_PINGPONG_EN
          m_mode = M_UP;
          m_cnt  = 1;
`else
          m_cnt  = 15;
`endif
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end else if (v) begin
      case (c)
        2'b00: begin m_mode = M_UP;   m_next_step = m_edge + DIV; end
        2'b01: begin m_mode = M_DOWN; m_next_step = m_edge + DIV; end
        2'b10: if (m_mode == M_UP || m_mode == M_DOWN) m_mode = M_PAUSED;
        default: begin m_mode = M_IDLE; m_cnt = 0; end
      endcase
    end
  endtask

  // driver: one clock cycle with the given inputs, checked before and after the edge
  task automatic drive_cycle(input logic v, input logic [1:0] c, input logic rn);
    @(negedge clk);
    cmd_valid = v;
    cmd       = c;
    rst       = rn;
    #1;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready()));
    @(posedge clk);
    model_edge(v, c, rn);
    #1;
    check("out",  32'(out),  32'(m_cnt));
    check("DS",   32'(DS),   32'(exp_ds()));
    check("tc",   32'(tc),   32'(m_tc));
    check("busy", 32'(busy), 32'((m_mode == M_UP || m_mode == M_DOWN) ? 1 : 0));
    check("sett", 32'(sett), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'b00, 1'b1);
  endtask

  initial begin
    int guard;
    n_checks    = 0;
    n_fail      = 0;
    m_mode      = M_IDLE;
    m_cnt       = 0;
    m_tc        = 0;
    m_edge      = 0;
    m_next_step = 0;
    cmd_valid   = 1'b0;
    cmd         = 2'b00;
    rst         = 1'b0;

    // reset held for two cycles
    drive_cycle(1'b0, 2'b00, 1'b0);
    drive_cycle(1'b0, 2'b00, 1'b0);

    // UP from 0, run past the 15 -> 0 wrap
    drive_cycle(1'b1, 2'b00, 1'b1);
    idle_cycles(17 * DIV);

    // DOWN from 0: first step wraps to 15
    drive_cycle(1'b1, 2'b11, 1'b1);
    drive_cycle(1'b1, 2'b01, 1'b1);
    idle_cycles(2 * DIV + 1);

    // UP, 6 cycles, PAUSE, hold, resume
    drive_cycle(1'b1, 2'b00, 1'b1);
    idle_cycles(6);
    drive_cycle(1'b1, 2'b10, 1'b1);
    idle_cycles(10);
    drive_cycle(1'b1, 2'b10, 1'b1);
    drive_cycle(1'b1, 2'b00, 1'b1);
    idle_cycles(DIV + 2);

    // UP in RUN_UP restarts the period
    idle_cycles(2);
    drive_cycle(1'b1, 2'b00, 1'b1);
    idle_cycles(DIV + 1);

    // CLEAR held across a tick cycle: step first, CLEAR on the next edge
    guard = 0;
    while (exp_ready() == 1 && guard < 4 * DIV) begin
      idle_cycles(1);
      guard++;
    end
    check("tick_found", 32'(exp_ready()), 32'd0);
    drive_cycle(1'b1, 2'b11, 1'b1);
    drive_cycle(1'b1, 2'b11, 1'b1);
    check("clear_out", 32'(out), 32'd0);
    drive_cycle(1'b0, 2'b00, 1'b1);

    // long up run through 14, 15 and beyond (reversal in ping-pong builds)
    drive_cycle(1'b1, 2'b00, 1'b1);
    idle_cycles(20 * DIV);

    // mid-run reset
    drive_cycle(1'b0, 2'b00, 1'b0);
    idle_cycles(3);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [1:0] c;
      logic       rn;
      v  = ($urandom_range(0, 7) == 0);
      c  = 2'($urandom_range(0, 9) < 4 ? $urandom_range(0, 1) : $urandom_range(0, 3));
      rn = ($urandom_range(0, 299) != 0);
      if (i % 40 < 4) v = 1'b1;  // short bursts of held commands
      drive_cycle(v, c, rn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
